fetch_buffer: RTL

//  Instruction fetch queue between the PC register / instruction memory and decode.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_buffer.sv | 100 ++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch queue
package fetch_pkg;

    localparam int FETCH_ADDRESS_WIDTH = 32;
    localparam int FETCH_DATA_WIDTH    = 32;

    // addi x0, x0, 0: presented to decode whenever the queue is empty
    localparam logic [FETCH_DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_ADDRESS_WIDTH-1:0] pc;
        logic [FETCH_ADDRESS_WIDTH-1:0] pc_plus4;
        logic [FETCH_DATA_WIDTH-1:0]    instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - instruction fetch queue between PC/imem and decode
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   f_valid/f_ready               fetch handshake; push = f_valid & f_ready
//   f_pc, f_pc_plus4, f_instr     offered entry
//   flush                         discard all entries, ignore same-cycle push/pop
//   d_valid/d_ready               decode handshake; pop = d_valid & d_ready
//   d_pc, d_pc_plus4, d_instr     head entry (0/0/NOP when empty)
//   count                         current occupancy
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int ADDRESS_WIDTH = FETCH_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = FETCH_DATA_WIDTH,
    parameter int DEPTH         = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       f_valid,
    output logic                       f_ready,
    input  logic [ADDRESS_WIDTH-1:0]   f_pc,
    input  logic [ADDRESS_WIDTH-1:0]   f_pc_plus4,
    input  logic [DATA_WIDTH-1:0]      f_instr,
    input  logic                       flush,
    output logic                       d_valid,
    input  logic                       d_ready,
    output logic [ADDRESS_WIDTH-1:0]   d_pc,
    output logic [ADDRESS_WIDTH-1:0]   d_pc_plus4,
    output logic [DATA_WIDTH-1:0]      d_instr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_entry_t        mem [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic                push;
    logic                pop;

    // Handshake flags come from registered occupancy only, so f_ready has
    // no combinational dependence on d_ready (no pop-through when full).
    assign f_ready = (count != DEPTH_C);
    assign d_valid = (count != '0);

    assign push = f_valid & f_ready & ~flush;
    assign pop  = d_valid & d_ready & ~flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            // Collapsing rd_ptr onto wr_ptr empties the queue without
            // touching storage.
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is intentionally not reset; d_* are masked while empty.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr].pc       <= f_pc;
            mem[wr_ptr].pc_plus4 <= f_pc_plus4;
            mem[wr_ptr].instr    <= f_instr;
        end
    end

    always_comb begin
        d_pc       = '0;
        d_pc_plus4 = '0;
        d_instr    = NOP_INSTR;
        if (d_valid) begin
            d_pc       = mem[rd_ptr].pc;
            d_pc_plus4 = mem[rd_ptr].pc_plus4;
            d_instr    = mem[rd_ptr].instr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (count <= DEPTH_C)
                else $error("fetch_buffer occupancy out of range: %0d", count);
        end
    end

endmodule
